ofm_drain: RTL and testbench

//  Output-drain stage directly downstream of the 16-bit binary-serial systolic array.
//  - Generates the column-skewed en_o/clr_o shift controls.
//  - Captures the HEIGHT partial sums each column shifts out on ofm[w].
//  - Deskews the columns into whole output rows, buffers them in a row FIFO and

---
 rtl/ofm_drain.sv | 173 +++++++++++++++++
 tb/tb_ofm_drain.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ofm_drain.sv
// Output drain behind the systolic array: skewed en/clr generation, column deskew and a row FIFO.
// First row is pushed WIDTH+OFM_LAT cycles after accept; out_ready only gates the next start, never an active drain.
module ofm_drain #(
  parameter int HEIGHT     = 32,
  parameter int WIDTH      = 32,
  parameter int OWIDTH     = 32,
  parameter int OFM_LAT    = 1,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  output logic                          start_ready,
  output logic                          busy,
  output logic                          done,
  output logic [WIDTH-1:0]              en_o,
  output logic [WIDTH-1:0]              clr_o,
  input  logic signed [OWIDTH-1:0]      ofm [WIDTH-1:0],
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH*OWIDTH-1:0]       out_data,
  output logic                          out_last,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = $clog2(HEIGHT + 1);
  localparam int DW = WIDTH * OWIDTH + 1;
  localparam logic [CW-1:0] CNT_ACCEPT_MAX = CW'(FIFO_DEPTH - HEIGHT);
  localparam logic [CW-1:0] CNT_FULL       = CW'(FIFO_DEPTH);
  localparam logic [RW-1:0] ROW_LAST       = RW'(HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic                    accept;
  logic                    push;
  logic                    pop;
  logic                    last_push;
  logic                    full;
  logic                    empty;
  logic [RW-1:0]           en_cnt;
  logic [RW-1:0]           row_cnt;
  logic [WIDTH-1:0]        cap;
  logic [WIDTH-1:0]        cap_pipe [OFM_LAT];
  logic [WIDTH*OWIDTH-1:0] row_dat;
  logic [DW-1:0]           mem [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = DRAIN;
      DRAIN:   if (last_push) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Space for a whole drain is reserved at accept, so the drain itself never stalls.
  always_comb begin
    start_ready = (state == IDLE) && (fifo_cnt <= CNT_ACCEPT_MAX);
    busy        = (state != IDLE);
    done        = (state == DONE);
  end

  assign accept = start && start_ready;

  // Column 0 is generated from a row counter; the other columns are the same pulses shifted by w.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_o   <= '0;
      clr_o  <= '0;
      en_cnt <= '0;
    end else begin
      for (int w = WIDTH - 1; w > 0; w--) begin
        en_o[w]  <= en_o[w-1];
        clr_o[w] <= clr_o[w-1];
      end
      clr_o[0] <= 1'b0;
      if (accept) begin
        en_o[0] <= 1'b1;
        en_cnt  <= '0;
      end else if (en_o[0]) begin
        en_cnt <= en_cnt + 1'b1;
        if (en_cnt == ROW_LAST) begin
          en_o[0]  <= 1'b0;
          clr_o[0] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < OFM_LAT; i++) cap_pipe[i] <= '0;
    end else begin
      cap_pipe[0] <= en_o;
      for (int i = 1; i < OFM_LAT; i++) cap_pipe[i] <= cap_pipe[i-1];
    end
  end

  assign cap = cap_pipe[OFM_LAT-1];

  // Column w waits WIDTH-1-w cycles so every column of row k lines up with column WIDTH-1.
  for (genvar w = 0; w < WIDTH; w++) begin : g_col
    if (w == WIDTH - 1) begin : g_pass
      assign row_dat[w*OWIDTH +: OWIDTH] = ofm[w];
    end else begin : g_dly
      localparam int N = WIDTH - 1 - w;
      logic [OWIDTH-1:0] dl [N];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < N; i++) dl[i] <= '0;
        end else begin
          if (cap[w]) dl[0] <= ofm[w];
          for (int i = 1; i < N; i++) dl[i] <= dl[i-1];
        end
      end
      assign row_dat[w*OWIDTH +: OWIDTH] = dl[N-1];
    end
  end

  assign push      = cap[WIDTH-1];
  assign last_push = push && (row_cnt == ROW_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    row_cnt <= '0;
    else if (push) row_cnt <= last_push ? '0 : row_cnt + 1'b1;
  end

  assign empty     = (fifo_cnt == '0);
  assign full      = (fifo_cnt == CNT_FULL);
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {last_push, row_dat};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_comb begin
    out_data = '0;
    out_last = 1'b0;
    if (!empty) {out_last, out_data} = mem[rd_ptr];
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule

// File: tb/tb_ofm_drain.sv
`timescale 1ns/1ps
// Directed bench for ofm_drain: instance a (OFM_LAT=1) and b (OFM_LAT=3) fed by a small array model.
module tb_ofm_drain;
  localparam int H = 4, W = 4, OW = 32, FD = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic start_a, start_b, ready_a, ready_b, rnd_a;
  logic sr_a, busy_a, done_a, ov_a, last_a;
  logic sr_b, busy_b, done_b, ov_b, last_b;
  logic [W-1:0] en_a, clr_a, en_b, clr_b;
  logic [W*OW-1:0] dat_a, dat_b;
  logic [3:0] cnt_a, cnt_b;
  logic signed [OW-1:0] ofm_a [W-1:0];
  logic signed [OW-1:0] ofm_b [W-1:0];
  logic [31:0] base_a, base_b;
  logic [31:0] ha [W];
  logic [31:0] hb [W][3];
  int ka [W];
  int kb [W];
  logic [128:0] qa [$];
  logic [128:0] qb [$];
  int n_cmp = 0;
  int n_err = 0;

  // Expected per-cycle pattern of a drain with out_ready=1, index n-1 for cycle T+n.
  logic [3:0] t_en  [10] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
  logic [3:0] t_clr [10] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000};
  logic       t_ov  [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic       t_done[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic       t_busy[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  ofm_drain #(.HEIGHT(H), .WIDTH(W), .OWIDTH(OW), .OFM_LAT(1), .FIFO_DEPTH(FD)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .start_ready(sr_a), .busy(busy_a), .done(done_a),
    .en_o(en_a), .clr_o(clr_a), .ofm(ofm_a), .out_valid(ov_a), .out_ready(ready_a),
    .out_data(dat_a), .out_last(last_a), .fifo_cnt(cnt_a));

  ofm_drain #(.HEIGHT(H), .WIDTH(W), .OWIDTH(OW), .OFM_LAT(3), .FIFO_DEPTH(FD)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .start_ready(sr_b), .busy(busy_b), .done(done_b),
    .en_o(en_b), .clr_o(clr_b), .ofm(ofm_b), .out_valid(ov_b), .out_ready(ready_b),
    .out_data(dat_b), .out_last(last_b), .fifo_cnt(cnt_b));

  // Array model: sample k of column w is base ^ (16k+w), presented OFM_LAT cycles after its en.
  always @(negedge clk) begin
    for (int w = 0; w < W; w++) begin
      ofm_a[w] = ha[w];
      if (!rst_n || clr_a[w]) ka[w] = 0;
      if (rst_n && en_a[w]) begin
        ha[w] = base_a ^ 32'(16 * ka[w] + w);
        ka[w] = ka[w] + 1;
      end else begin
        ha[w] = 32'h0BAD_0000 | 32'(w);
      end
      ofm_b[w] = hb[w][2];
      hb[w][2] = hb[w][1];
      hb[w][1] = hb[w][0];
      if (!rst_n || clr_b[w]) kb[w] = 0;
      if (rst_n && en_b[w]) begin
        hb[w][0] = base_b ^ 32'(16 * kb[w] + w);
        kb[w] = kb[w] + 1;
      end else begin
        hb[w][0] = 32'h0BAD_0000 | 32'(w);
      end
    end
  end

  function automatic logic [128:0] mkrow(input logic [31:0] b, input int k);
    logic [128:0] r;
    r[128] = (k == H - 1);
    for (int w = 0; w < W; w++) r[w*32 +: 32] = b ^ 32'(16 * k + w);
    return r;
  endfunction

  task automatic exp_a(input logic [31:0] b);
    for (int k = 0; k < H; k++) qa.push_back(mkrow(b, k));
  endtask

  task automatic exp_b(input logic [31:0] b);
    for (int k = 0; k < H; k++) qb.push_back(mkrow(b, k));
  endtask

  task automatic chk(input string tag, input logic [128:0] obs, input logic [128:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Checks any row leaving this cycle, then advances to the next falling edge.
  task automatic tick();
    if (ov_a && ready_a) begin
      chk("a_row_expected", 129'(qa.size() != 0), 129'(1));
      if (qa.size() != 0) chk("a_row", {last_a, dat_a}, qa.pop_front());
    end
    if (ov_b && ready_b) begin
      chk("b_row_expected", 129'(qb.size() != 0), 129'(1));
      if (qb.size() != 0) chk("b_row", {last_b, dat_b}, qb.pop_front());
    end
    @(negedge clk);
    if (rnd_a) ready_a = 1'($urandom_range(0, 1));
  endtask

  task automatic drain_tab(input bit hold, input logic [31:0] b);
    int ndone;
    ndone = 0;
    base_a = b;
    exp_a(b);
    start_a = 1'b1;
    tick();
    for (int n = 1; n <= 12; n++) begin
      if (!hold || n >= 8) start_a = 1'b0;
      if (n <= 10) begin
        chk("tab_en",   129'(en_a),   129'(t_en[n-1]));
        chk("tab_clr",  129'(clr_a),  129'(t_clr[n-1]));
        chk("tab_ov",   129'(ov_a),   129'(t_ov[n-1]));
        chk("tab_done", 129'(done_a), 129'(t_done[n-1]));
        chk("tab_busy", 129'(busy_a), 129'(t_busy[n-1]));
      end
      ndone = ndone + int'(done_a);
      tick();
    end
    start_a = 1'b0;
    chk("done_pulses", 129'(ndone), 129'(1));
    chk("drain_rows_left", 129'(qa.size()), 129'(0));
  endtask

  initial begin
    start_a = 1'b0; start_b = 1'b0; ready_a = 1'b1; ready_b = 1'b1; rnd_a = 1'b0;
    base_a = '0; base_b = '0;
    repeat (2) @(negedge clk);

    chk("rst_en",   129'(en_a),   129'(0));
    chk("rst_clr",  129'(clr_a),  129'(0));
    chk("rst_busy", 129'(busy_a), 129'(0));
    chk("rst_done", 129'(done_a), 129'(0));
    chk("rst_ov",   129'(ov_a),   129'(0));
    chk("rst_cnt",  129'(cnt_a),  129'(0));
    chk("rst_dat",  129'({last_a, dat_a}), 129'(0));
    rst_n = 1'b1;
    tick();
    chk("idle_start_ready", 129'(sr_a), 129'(1));

    // 1: basic drain, spec values 16k+w
    drain_tab(1'b0, 32'h0);
    chk("t1_cnt", 129'(cnt_a), 129'(0));

    // 2: consumer stalled across two drains
    ready_a = 1'b0;
    base_a = 32'h100; exp_a(base_a);
    start_a = 1'b1; tick(); start_a = 1'b0;
    repeat (11) tick();
    chk("t2_cnt4", 129'(cnt_a), 129'(4));
    chk("t2_sr4",  129'(sr_a),  129'(1));
    base_a = 32'h200; exp_a(base_a);
    start_a = 1'b1; tick(); start_a = 1'b0;
    repeat (11) tick();
    chk("t2_cnt8", 129'(cnt_a), 129'(8));
    chk("t2_sr8",  129'(sr_a),  129'(0));
    start_a = 1'b1; tick(); start_a = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("t2_ign_en",   129'(en_a),   129'(0));
      chk("t2_ign_busy", 129'(busy_a), 129'(0));
      tick();
    end
    ready_a = 1'b1; tick(); ready_a = 1'b0;
    chk("t2_cnt7", 129'(cnt_a), 129'(7));
    chk("t2_sr7",  129'(sr_a),  129'(0));
    repeat (3) begin
      ready_a = 1'b1; tick(); ready_a = 1'b0;
    end
    chk("t2_cnt4b", 129'(cnt_a), 129'(4));
    chk("t2_sr4b",  129'(sr_a),  129'(1));
    ready_a = 1'b1;
    repeat (5) tick();
    chk("t2_rows_left", 129'(qa.size()), 129'(0));
    chk("t2_cnt0", 129'(cnt_a), 129'(0));

    // 3: random consumer during a drain
    base_a = 32'h300; exp_a(base_a);
    start_a = 1'b1; tick(); start_a = 1'b0;
    rnd_a = 1'b1;
    repeat (30) tick();
    rnd_a = 1'b0; ready_a = 1'b1;
    repeat (10) tick();
    chk("t3_rows_left", 129'(qa.size()), 129'(0));
    chk("t3_cnt0", 129'(cnt_a), 129'(0));

    // 4: start held while busy
    drain_tab(1'b1, 32'h400);

    // 5: reset at T+3 with rows already buffered
    ready_a = 1'b0;
    base_a = 32'h480;
    start_a = 1'b1; tick(); start_a = 1'b0;
    repeat (11) tick();
    base_a = 32'h500;
    start_a = 1'b1; tick(); start_a = 1'b0;
    tick(); tick();
    chk("t5_pre_en", 129'(en_a), 129'(4'b0111));
    chk("t5_pre_ov", 129'(ov_a), 129'(1));
    rst_n = 1'b0;
    #1;
    chk("t5_en",   129'(en_a),   129'(0));
    chk("t5_clr",  129'(clr_a),  129'(0));
    chk("t5_ov",   129'(ov_a),   129'(0));
    chk("t5_busy", 129'(busy_a), 129'(0));
    chk("t5_cnt",  129'(cnt_a),  129'(0));
    tick();
    rst_n = 1'b1;
    ready_a = 1'b1;
    drain_tab(1'b0, 32'h600);

    // 6: OFM_LAT=3, extreme signed values
    base_b = 32'h8000_0000; exp_b(base_b);
    start_b = 1'b1; tick(); start_b = 1'b0;
    for (int n = 1; n <= 13; n++) begin
      if (n == 7)  chk("t6_ov_t7",   129'(ov_b),   129'(0));
      if (n == 8)  chk("t6_ov_t8",   129'(ov_b),   129'(1));
      if (n == 10) chk("t6_done_t10", 129'(done_b), 129'(0));
      if (n == 11) chk("t6_done_t11", 129'(done_b), 129'(1));
      if (n == 11) chk("t6_busy_t11", 129'(busy_b), 129'(1));
      if (n == 12) chk("t6_done_t12", 129'(done_b), 129'(0));
      if (n == 12) chk("t6_busy_t12", 129'(busy_b), 129'(0));
      tick();
    end
    base_b = 32'hFFFF_FFFF; exp_b(base_b);
    start_b = 1'b1; tick(); start_b = 1'b0;
    repeat (14) tick();
    chk("t6_rows_left", 129'(qb.size()), 129'(0));
    chk("t6_cnt0", 129'(cnt_b), 129'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
